alu_issue_stage: RTL and testbench

//  Issue/writeback stage directly upstream of the combinational alu (alu_pkg).
//  - Accepts commands over a valid/ready stream and holds a REGS-entry x N-bit register file.
//  - Drives the alu A/B/opcode from that file and writes the alu result Y back into it.
//  - Returns each result on a valid/ready response stream.

---
 rtl/alu_issue_if.sv | 39 +++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Command, response and alu-side signal bundle for alu_issue_stage.
// slave = the issue stage; master = the command source / response sink / alu side.
interface alu_issue_if #(
    parameter int N  = 8,
    parameter int RA = 2
);
    logic          in_valid;
    logic          in_ready;
    logic          in_load;
    logic [2:0]    in_opcode;
    logic [RA-1:0] in_rd;
    logic [RA-1:0] in_rs1;
    logic [RA-1:0] in_rs2;
    logic [N-1:0]  in_imm;

    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_opcode;
    logic [N-1:0]  alu_y;

    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic [RA-1:0] res_rd;

    modport slave (
        input  in_valid, in_load, in_opcode, in_rd, in_rs1, in_rs2, in_imm,
        input  alu_y, res_ready,
        output in_ready, alu_a, alu_b, alu_opcode,
        output res_valid, res_data, res_rd
    );

    modport master (
        output in_valid, in_load, in_opcode, in_rd, in_rs1, in_rs2, in_imm,
        output alu_y, res_ready,
        input  in_ready, alu_a, alu_b, alu_opcode,
        input  res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a combinational alu: one command in flight,
// sources read from a small register file, result written back and returned.
module alu_issue_stage #(
    parameter int N    = 8,
    parameter int REGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam int RA = (REGS > 1) ? $clog2(REGS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic          load;
        logic [2:0]    opcode;
        logic [RA-1:0] rd;
        logic [RA-1:0] rs1;
        logic [RA-1:0] rs2;
        logic [N-1:0]  imm;
    } cmd_t;

    state_t                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [REGS-1:0][N-1:0] rf_q, rf_d;
    logic                   res_valid_q, res_valid_d;
    logic [N-1:0]           res_data_q, res_data_d;
    logic [RA-1:0]          res_rd_q, res_rd_d;

    logic [N-1:0]           src_a;
    logic [N-1:0]           src_b;
    logic [N-1:0]           wr_val;

    // Index decode by comparison: an index with no matching entry reads as 0.
    always_comb begin
        src_a = '0;
        src_b = '0;
        for (int i = 0; i < REGS; i++) begin
            if (cmd_q.rs1 == RA'(i)) src_a = rf_q[i];
            if (cmd_q.rs2 == RA'(i)) src_b = rf_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rf_d        = rf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        wr_val      = cmd_q.load ? cmd_q.imm : bus.alu_y;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cmd_d.load   = bus.in_load;
                    cmd_d.opcode = bus.in_opcode;
                    cmd_d.rd     = bus.in_rd;
                    cmd_d.rs1    = bus.in_rs1;
                    cmd_d.rs2    = bus.in_rs2;
                    cmd_d.imm    = bus.in_imm;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Write lands on this edge; an unmatched rd drops the write.
                for (int i = 0; i < REGS; i++) begin
                    if (cmd_q.rd == RA'(i)) rf_d[i] = wr_val;
                end
                res_data_d  = wr_val;
                res_rd_d    = cmd_q.rd;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rf_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rf_q        <= rf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
        end
    end

    // alu operands come only from latched state, never straight from in_*.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.alu_a      = src_a;
    assign bus.alu_b      = src_b;
    assign bus.alu_opcode = cmd_q.opcode;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_rd     = res_rd_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural alu on the alu port, directed scenarios
// plus a randomized run checked against an array-based register-file model.
module tb_alu_issue_stage;
    localparam int N    = 8;
    localparam int REGS = 4;
    localparam int RA   = 2;

    typedef struct packed {
        logic       ld;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       to;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] rf_m [REGS];

    alu_issue_if #(.N(N), .RA(RA)) bus ();

    alu_issue_stage #(.N(N), .REGS(REGS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a - 8'd1;
            3'd3: return a + 8'd1;
            3'd4: return ~a;
            3'd5: return a & b;
            3'd6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb bus.alu_y = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

    function automatic cmd_t mk(input bit ld, input int op, input int rd, input int rs1, input int rs2, input int imm);
        cmd_t c;
        c.ld = ld; c.op = 3'(op); c.rd = 2'(rd); c.rs1 = 2'(rs1); c.rs2 = 2'(rs2); c.imm = 8'(imm);
        return c;
    endfunction

    // Reference: sources read before the write, result mod 256.
    function automatic logic [7:0] model_step(input cmd_t c);
        logic [7:0] v;
        v = c.ld ? c.imm : alu_f(c.op, rf_m[c.rs1], rf_m[c.rs2]);
        rf_m[c.rd] = v;
        return v;
    endfunction

    // Called at a negedge; returns at a negedge with the stage back in IDLE.
    task automatic issue(input cmd_t c, input int hold, output obs_t o);
        int n;
        o = '0;
        bus.in_valid = 1'b1; bus.in_load = c.ld; bus.in_opcode = c.op;
        bus.in_rd = c.rd; bus.in_rs1 = c.rs1; bus.in_rs2 = c.rs2; bus.in_imm = c.imm;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bus.in_ready !== 1'b1) begin bus.in_valid = 1'b0; o.to = 1'b1; return; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        o.a = bus.alu_a; o.b = bus.alu_b; o.op = bus.alu_opcode;
        @(negedge clk);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bus.res_valid !== 1'b1) begin o.to = 1'b1; return; end
        repeat (hold) @(negedge clk);
        o.data = bus.res_data; o.rd = bus.res_rd;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 || bus.res_rd !== 2'd0) begin
            bad++; $display("FAIL reset_res: valid=%b data=%h rd=%0d want 0 00 0", bus.res_valid, bus.res_data, bus.res_rd);
        end
        total++;
        if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_opcode !== 3'd0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_alu: a=%h b=%h op=%0d rdy=%b want 00 00 0 1", bus.alu_a, bus.alu_b, bus.alu_opcode, bus.in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < REGS; i++) rf_m[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_basic();
        cmd_t       cs [3];
        logic [7:0] ed [3];
        logic [7:0] v;
        obs_t       o;
        cs[0] = mk(1, 0, 0, 0, 0, 8'h05); ed[0] = 8'h05;
        cs[1] = mk(1, 0, 1, 0, 0, 8'h03); ed[1] = 8'h03;
        cs[2] = mk(0, 0, 2, 0, 1, 8'h00); ed[2] = 8'h08;
        for (int i = 0; i < 3; i++) begin
            issue(cs[i], 0, o);
            v = model_step(cs[i]);
            total++;
            if (o.to || o.data !== ed[i] || o.rd !== cs[i].rd) begin
                bad++; $display("FAIL basic_%0d: data=%h rd=%0d to=%b want %h %0d", i, o.data, o.rd, o.to, ed[i], cs[i].rd);
            end
        end
        total++;
        if (o.a !== 8'h05 || o.b !== 8'h03 || o.op !== 3'd0) begin
            bad++; $display("FAIL basic_src: a=%h b=%h op=%0d want 05 03 0", o.a, o.b, o.op);
        end
    endtask

    task automatic test_wrap();
        cmd_t       cs [3];
        logic [7:0] ed [3];
        logic [7:0] ea [3];
        logic [7:0] v;
        obs_t       o;
        cs[0] = mk(1, 0, 0, 0, 0, 8'hFF); ed[0] = 8'hFF; ea[0] = 8'h00;
        cs[1] = mk(0, 3, 0, 0, 0, 8'h00); ed[1] = 8'h00; ea[1] = 8'hFF;
        cs[2] = mk(0, 2, 0, 0, 0, 8'h00); ed[2] = 8'hFF; ea[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            issue(cs[i], 0, o);
            v = model_step(cs[i]);
            total++;
            if (o.to || o.data !== ed[i] || (i > 0 && o.a !== ea[i])) begin
                bad++; $display("FAIL wrap_%0d: data=%h a=%h to=%b want %h a=%h", i, o.data, o.a, o.to, ed[i], ea[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t       o;
        logic [7:0] v;
        int         errs;
        bus.res_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_opcode = 3'd0;
        bus.in_rd = 2'd3; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0; bus.in_imm = 8'h5A;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle: in_ready=%b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        // A second command offered while the response is stalled.
        bus.in_valid = 1'b1; bus.in_imm = 8'h77; bus.in_rd = 2'd3;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h5A || bus.res_rd !== 2'd3 || bus.in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold_%0d: valid=%b data=%h rd=%0d rdy=%b want 1 5a 3 0", i, bus.res_valid, bus.res_data, bus.res_rd, bus.in_ready);
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) bad++;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: valid=%b rdy=%b want 0 1", bus.res_valid, bus.in_ready);
        end
        rf_m[3] = 8'h5A;
        // r3 must still hold the first load; the stalled offer had no effect.
        issue(mk(0, 3, 3, 3, 0, 0), 0, o);
        v = model_step(mk(0, 3, 3, 3, 0, 0));
        total++;
        if (o.to || o.a !== 8'h5A || o.data !== 8'h5B) begin
            bad++; $display("FAIL bp_rf: a=%h data=%h to=%b want 5a 5b", o.a, o.data, o.to);
        end
    endtask

    task automatic test_throughput();
        cmd_t       cs [4];
        logic [7:0] ed [4];
        int         acc [$];
        logic [7:0] gd [$];
        logic [1:0] gr [$];
        int         k;
        int         cyc;
        int         errs;
        for (int i = 0; i < 4; i++) begin
            cs[i] = mk($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            ed[i] = model_step(cs[i]);
        end
        k = 0; cyc = 0;
        bus.res_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_load = cs[0].ld; bus.in_opcode = cs[0].op;
        bus.in_rd = cs[0].rd; bus.in_rs1 = cs[0].rs1; bus.in_rs2 = cs[0].rs2; bus.in_imm = cs[0].imm;
        while ((k < 4 || gd.size() < 4) && cyc < 60) begin
            if (bus.res_valid === 1'b1) begin gd.push_back(bus.res_data); gr.push_back(bus.res_rd); end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin acc.push_back(cyc); k++; end
            @(negedge clk);
            cyc++;
            if (k < 4) begin
                bus.in_load = cs[k].ld; bus.in_opcode = cs[k].op; bus.in_rd = cs[k].rd;
                bus.in_rs1 = cs[k].rs1; bus.in_rs2 = cs[k].rs2; bus.in_imm = cs[k].imm;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;
        total++;
        if (acc.size() != 4 || gd.size() != 4) begin
            bad++; $display("FAIL tput_count: accepts=%0d responses=%0d want 4 4", acc.size(), gd.size());
        end else begin
            errs = 0;
            for (int i = 1; i < 4; i++) if (acc[i] - acc[i-1] != 3) errs++;
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL tput_spacing: accept cycles %0d %0d %0d %0d want spacing 3", acc[0], acc[1], acc[2], acc[3]);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (gd[i] !== ed[i] || gr[i] !== cs[i].rd) begin
                    bad++; $display("FAIL tput_resp_%0d: data=%h rd=%0d want %h %0d", i, gd[i], gr[i], ed[i], cs[i].rd);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t       o;
        logic [7:0] v;
        issue(mk(1, 0, 1, 0, 0, 8'h33), 0, o);
        v = model_step(mk(1, 0, 1, 0, 0, 8'h33));
        bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_opcode = 3'd3;
        bus.in_rd = 2'd2; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd0; bus.in_imm = 8'h00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.alu_a !== 8'h33 || bus.alu_opcode !== 3'd3 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_exec: a=%h op=%0d rdy=%b want 33 3 0", bus.alu_a, bus.alu_opcode, bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.alu_a !== 8'h00 || bus.alu_opcode !== 3'd0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_async: valid=%b a=%h op=%0d rdy=%b want 0 00 0 1", bus.res_valid, bus.alu_a, bus.alu_opcode, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < REGS; i++) rf_m[i] = 8'h00;
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rmid_noresp: res_valid=%b want 0", bus.res_valid); end
        for (int i = 0; i < REGS; i++) begin
            issue(mk(0, 6, i, i, i, 0), 0, o);
            v = model_step(mk(0, 6, i, i, i, 0));
            total++;
            if (o.to || o.a !== 8'h00 || o.b !== 8'h00 || o.data !== 8'h00) begin
                bad++; $display("FAIL rmid_rf%0d: a=%h b=%h data=%h to=%b want 00 00 00", i, o.a, o.b, o.data, o.to);
            end
        end
        test_basic();
    endtask

    task automatic test_all_ops();
        logic [7:0] ed [8];
        logic [7:0] v;
        obs_t       o;
        ed = '{8'hE1, 8'h69, 8'hA4, 8'hA6, 8'h5A, 8'h24, 8'hBD, 8'h99};
        issue(mk(1, 0, 0, 0, 0, 8'hA5), 0, o); v = model_step(mk(1, 0, 0, 0, 0, 8'hA5));
        issue(mk(1, 0, 1, 0, 0, 8'h3C), 0, o); v = model_step(mk(1, 0, 1, 0, 0, 8'h3C));
        for (int op = 0; op < 8; op++) begin
            issue(mk(0, op, 2, 0, 1, 0), 0, o);
            v = model_step(mk(0, op, 2, 0, 1, 0));
            total++;
            if (o.to || o.data !== ed[op] || o.a !== 8'hA5 || o.b !== 8'h3C || o.op !== 3'(op)) begin
                bad++; $display("FAIL op%0d: data=%h a=%h b=%h op=%0d to=%b want %h a5 3c %0d", op, o.data, o.a, o.b, o.op, o.to, ed[op], op);
            end
        end
    endtask

    task automatic test_random();
        cmd_t       c;
        obs_t       o;
        logic [7:0] ea, eb, ev;
        for (int i = 0; i < 40; i++) begin
            c = mk($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            ea = rf_m[c.rs1];
            eb = rf_m[c.rs2];
            ev = model_step(c);
            issue(c, $urandom_range(0, 3), o);
            total++;
            if (o.to || o.data !== ev || o.rd !== c.rd || o.a !== ea || o.b !== eb || o.op !== c.op) begin
                bad++;
                $display("FAIL rand_%0d: data=%h rd=%0d a=%h b=%h op=%0d to=%b want %h %0d %h %h %0d",
                         i, o.data, o.rd, o.a, o.b, o.op, o.to, ev, c.rd, ea, eb, c.op);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_opcode = 3'd0;
        bus.in_rd = 2'd0; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0; bus.in_imm = 8'h00;
        bus.res_ready = 1'b0;
        for (int i = 0; i < REGS; i++) rf_m[i] = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_all_ops();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
